// File: rtl/pwm_ramp_ctrl.sv
// Fade/ramp sequencer: steps a pwm compare value from START_V to END_V through
// a master write port, pacing each write by a programmable divider.
module pwm_ramp_ctrl #(
  parameter int pwm_width = 8,
  parameter int div_width = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [31:0] m_wd,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STEP} state_t;

  state_t                 r_state;
  logic [pwm_width-1:0]   r_start_v;
  logic [pwm_width-1:0]   r_end_v;
  logic [pwm_width-1:0]   r_step;
  logic [div_width-1:0]   r_div;
  logic                   r_loop;
  logic                   r_up;
  logic [pwm_width-1:0]   r_cur;
  logic [div_width-1:0]   r_cnt;
  logic                   r_done;

  logic                   w_busy;
  logic                   w_ctrl_wr;
  logic                   w_start;
  logic                   w_stop;
  logic [pwm_width-1:0]   w_step_eff;
  logic [pwm_width:0]     w_sum;
  logic [pwm_width:0]     w_diff;
  logic [pwm_width-1:0]   w_next;
  logic                   w_unused;

  assign w_busy     = (r_state != S_IDLE);
  assign w_ctrl_wr  = we && (addr[4:0] == 5'h00);
  assign w_stop     = w_ctrl_wr && wd[1];
  assign w_start    = w_ctrl_wr && wd[0] && !wd[1];
  assign w_step_eff = (r_step == '0) ? pwm_width'(1) : r_step;

  // Extra bit catches carry/borrow so the ramp clamps at END_V instead of wrapping.
  assign w_sum  = {1'b0, r_cur} + {1'b0, w_step_eff};
  assign w_diff = {1'b0, r_cur} - {1'b0, w_step_eff};

  always_comb begin
    w_next = r_end_v;
    if (r_up) begin
      if (!w_sum[pwm_width] && (w_sum[pwm_width-1:0] < r_end_v))
        w_next = w_sum[pwm_width-1:0];
    end else begin
      if (!w_diff[pwm_width] && (w_diff[pwm_width-1:0] > r_end_v))
        w_next = w_diff[pwm_width-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_start_v <= '0;
      r_end_v   <= '0;
      r_step    <= '0;
      r_div     <= '0;
      r_loop    <= 1'b0;
      r_up      <= 1'b0;
      r_cur     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_ctrl_wr)
        r_loop <= wd[2];
      if (we && !w_busy) begin
        case (addr[4:0])
          5'h04: r_start_v <= wd[pwm_width-1:0];
          5'h08: r_end_v   <= wd[pwm_width-1:0];
          5'h0C: r_step    <= wd[pwm_width-1:0];
          5'h10: r_div     <= wd[div_width-1:0];
          default: ;
        endcase
      end
      if (w_stop) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_cur   <= r_start_v;
              r_done  <= 1'b0;
              r_up    <= (r_end_v >= r_start_v);
              r_state <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_cnt   <= r_div;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (r_cnt == '0) r_state <= S_STEP;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          S_STEP: begin
            if (r_cur == r_end_v) begin
              if (r_loop) begin
                r_cur   <= r_start_v;
                r_state <= S_LOAD;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_cur   <= w_next;
              r_state <= S_LOAD;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd = '0;
    case (addr[4:0])
      5'h00: rd[2:0]           = {r_loop, r_done, w_busy};
      5'h04: rd[pwm_width-1:0] = r_start_v;
      5'h08: rd[pwm_width-1:0] = r_end_v;
      5'h0C: rd[pwm_width-1:0] = r_step;
      5'h10: rd[div_width-1:0] = r_div;
      default: rd = '0;
    endcase
  end

  assign m_addr   = '0;
  assign m_we     = (r_state == S_LOAD);
  assign m_wd     = {{(32-pwm_width){1'b0}}, r_cur};
  assign done     = r_done;
  assign w_unused = ^{addr[31:5], wd};

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: table-driven register and ramp vectors plus
// hand-written loop, stop, and reset sequences.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_wd;
  logic        done;

  int total = 0;
  int bad   = 0;

  pwm_ramp_ctrl #(.pwm_width(8), .div_width(16)) dut (
    .clk(clk), .resetn(resetn), .addr(addr), .we(we), .wd(wd), .rd(rd),
    .m_addr(m_addr), .m_we(m_we), .m_wd(m_wd), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } reg_vec_t;

  typedef struct packed {
    logic [7:0]       sv;
    logic [7:0]       ev;
    logic [7:0]       st;
    logic [15:0]      dv;
    logic [2:0]       n;
    logic [3:0][7:0]  ew;
  } ramp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wd = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic run_ramp(input ramp_t r, input int id);
    int          np;
    int          pc [8];
    logic [31:0] pv [8];
    int          done_c;
    int          win;
    logic [31:0] v;
    np = 0; done_c = -1;
    win = int'(r.n) * (int'(r.dv) + 3) + 4;
    bus_write(32'h04, {24'h0, r.sv});
    bus_write(32'h08, {24'h0, r.ev});
    bus_write(32'h0C, {24'h0, r.st});
    bus_write(32'h10, {16'h0, r.dv});
    bus_write(32'h00, 32'h1);
    for (int c = 0; c < win; c++) begin
      if (m_we) begin
        if (np < 8) begin pc[np] = c; pv[np] = m_wd; end
        np++;
      end
      if (done && done_c < 0) done_c = c;
      @(negedge clk);
    end
    chk($sformatf("ramp%0d_npulse", id), np, 32'(r.n));
    for (int i = 0; i < int'(r.n) && i < np && i < 8; i++) begin
      chk($sformatf("ramp%0d_wd%0d", id, i), pv[i], {24'h0, r.ew[i]});
      chk($sformatf("ramp%0d_at%0d", id, i), pc[i], i * (int'(r.dv) + 3));
    end
    chk($sformatf("ramp%0d_done_at", id), done_c, int'(r.n) * (int'(r.dv) + 3));
    bus_read(32'h00, v);
    chk($sformatf("ramp%0d_ctrl", id), v, 32'h2);
    $display("ramp %0d: sv=%h ev=%h step=%h div=%0d pulses=%0d", id, r.sv, r.ev, r.st, r.dv, np);
  endtask

  reg_vec_t rv [7];
  ramp_t    rt [6];

  initial begin
    logic [31:0] v;
    int          np;

    rv[0] = '{a:32'h04, d:32'hFFFFFFFF, exp:32'hFF};
    rv[1] = '{a:32'h08, d:32'hFFFFFFFF, exp:32'hFF};
    rv[2] = '{a:32'h0C, d:32'hFFFFFFFF, exp:32'hFF};
    rv[3] = '{a:32'h10, d:32'hFFFFFFFF, exp:32'hFFFF};
    rv[4] = '{a:32'h14, d:32'hFFFFFFFF, exp:32'h0};
    rv[5] = '{a:32'h04, d:32'h00000123, exp:32'h23};
    rv[6] = '{a:32'h10, d:32'h0001ABCD, exp:32'hABCD};

    rt[0] = '{sv:8'h10, ev:8'h40, st:8'h10, dv:16'd2, n:3'd4, ew:{8'h40, 8'h30, 8'h20, 8'h10}};
    rt[1] = '{sv:8'hF0, ev:8'hFF, st:8'h20, dv:16'd0, n:3'd2, ew:{8'h00, 8'h00, 8'hFF, 8'hF0}};
    rt[2] = '{sv:8'h40, ev:8'h00, st:8'h30, dv:16'd1, n:3'd3, ew:{8'h00, 8'h00, 8'h10, 8'h40}};
    rt[3] = '{sv:8'h02, ev:8'h00, st:8'h00, dv:16'd0, n:3'd3, ew:{8'h00, 8'h00, 8'h01, 8'h02}};
    rt[4] = '{sv:8'h55, ev:8'h55, st:8'h01, dv:16'd3, n:3'd1, ew:{8'h00, 8'h00, 8'h00, 8'h55}};
    rt[5] = '{sv:8'h00, ev:8'h05, st:8'h02, dv:16'd0, n:3'd4, ew:{8'h05, 8'h04, 8'h02, 8'h00}};

    resetn = 1'b0; we = 1'b0; addr = '0; wd = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    chk("rst_m_we", {31'h0, m_we}, 32'h0);
    chk("rst_m_wd", m_wd, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("m_addr", m_addr, 32'h0);
    bus_read(32'h00, v);
    chk("rst_ctrl", v, 32'h0);

    for (int i = 0; i < 7; i++) begin
      bus_write(rv[i].a, rv[i].d);
      bus_read(rv[i].a, v);
      chk($sformatf("reg%0d_%h", i, rv[i].a), v, rv[i].exp);
      $display("reg %0d: addr=%h wrote=%h read=%h", i, rv[i].a, rv[i].d, v);
    end

    for (int i = 0; i < 6; i++) run_ramp(rt[i], i);

    // LOOP: 0,1,2 repeating every 3 cycles
    bus_write(32'h04, 32'h0);
    bus_write(32'h08, 32'h2);
    bus_write(32'h0C, 32'h1);
    bus_write(32'h10, 32'h0);
    bus_write(32'h00, 32'h5);
    np = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_we) begin
        chk($sformatf("loop_at%0d", np), c, np * 3);
        chk($sformatf("loop_wd%0d", np), m_wd, 32'(np % 3));
        np++;
      end
      @(negedge clk);
    end
    chk("loop_npulse", np, 32'd7);
    chk("loop_done", {31'h0, done}, 32'h0);
    bus_write(32'h04, 32'h33);
    bus_read(32'h04, v);
    chk("busy_wr_ignored", v, 32'h0);
    bus_write(32'h00, 32'h2);
    bus_read(32'h00, v);
    chk("loop_stop_ctrl", v, 32'h0);
    np = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_we) np++;
      @(negedge clk);
    end
    chk("loop_stop_quiet", np, 32'd0);
    $display("loop: seq 0,1,2 then stop");

    // STOP during WAIT
    bus_write(32'h04, 32'h10);
    bus_write(32'h08, 32'h40);
    bus_write(32'h0C, 32'h10);
    bus_write(32'h10, 32'h5);
    bus_write(32'h00, 32'h1);
    chk("stop_first_we", {31'h0, m_we}, 32'h1);
    repeat (2) @(negedge clk);
    bus_write(32'h00, 32'h2);
    np = 0;
    for (int c = 0; c < 25; c++) begin
      if (m_we) np++;
      @(negedge clk);
    end
    chk("stop_quiet", np, 32'd0);
    chk("stop_done", {31'h0, done}, 32'h0);
    bus_read(32'h00, v);
    chk("stop_ctrl", v, 32'h0);
    $display("stop mid-wait: pulses_after=%0d", np);

    // START together with STOP: STOP wins
    bus_write(32'h00, 32'h3);
    np = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_we) np++;
      @(negedge clk);
    end
    chk("startstop_quiet", np, 32'd0);
    bus_read(32'h00, v);
    chk("startstop_ctrl", v, 32'h0);
    $display("start+stop: pulses=%0d", np);

    // Asynchronous reset mid-ramp
    bus_write(32'h00, 32'h1);
    repeat (2) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_m_we", {31'h0, m_we}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      bus_read(32'(i * 4), v);
      chk($sformatf("arst_reg%0d", i * 4), v, 32'h0);
    end
    @(negedge clk);
    resetn = 1'b1;
    $display("async reset mid-ramp applied");
    run_ramp(rt[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
